// File: rtl/dnn_stream_driver.sv
// Packs four signed samples into a DNN input vector, pulses the launch strobe and collects
// both DNN results for downstream delivery. Optional WAIT watchdog: define DNN_DRV_TIMEOUT_EN.
module dnn_stream_driver #(
  parameter int INPUT_WIDTH    = 5,
  parameter int OUTPUT_WIDTH   = 17,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [INPUT_WIDTH-1:0]  s_data,
  output logic                           dnn_in_ready,
  output logic signed [INPUT_WIDTH-1:0]  dnn_x0,
  output logic signed [INPUT_WIDTH-1:0]  dnn_x1,
  output logic signed [INPUT_WIDTH-1:0]  dnn_x2,
  output logic signed [INPUT_WIDTH-1:0]  dnn_x3,
  input  logic                           dnn_out0_ready,
  input  logic                           dnn_out1_ready,
  input  logic signed [OUTPUT_WIDTH-1:0] dnn_out0,
  input  logic signed [OUTPUT_WIDTH-1:0] dnn_out1,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic signed [OUTPUT_WIDTH-1:0] m_out0,
  output logic signed [OUTPUT_WIDTH-1:0] m_out1,
  output logic                           busy,
  output logic                           timeout_err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                         state_r;
  logic [1:0]                     idx_r;
  logic                           got0_r;
  logic                           got1_r;
  logic                           dnn_in_ready_r;
  logic                           m_valid_r;
  logic                           timeout_err_r;
  logic signed [INPUT_WIDTH-1:0]  x0_r, x1_r, x2_r, x3_r;
  logic signed [OUTPUT_WIDTH-1:0] m_out0_r, m_out1_r;
  logic                           cap0_s;
  logic                           cap1_s;
  logic                           pair_done_s;

`ifdef DNN_DRV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  // Capture qualifiers: a strobe only counts in WAIT and only for a result not yet held
  always_comb begin
    cap0_s      = 1'b0;
    cap1_s      = 1'b0;
    pair_done_s = 1'b0;
    if (state_r == WAIT) begin
      cap0_s      = dnn_out0_ready && !got0_r;
      cap1_s      = dnn_out1_ready && !got1_r;
      pair_done_s = (got0_r || dnn_out0_ready) && (got1_r || dnn_out1_ready);
    end else begin
      cap0_s      = 1'b0;
      cap1_s      = 1'b0;
      pair_done_s = 1'b0;
    end
  end

  // Control FSM with its registered outputs and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= FILL;
      idx_r          <= 2'd0;
      got0_r         <= 1'b0;
      got1_r         <= 1'b0;
      dnn_in_ready_r <= 1'b0;
      m_valid_r      <= 1'b0;
      timeout_err_r  <= 1'b0;
      x0_r           <= '0;
      x1_r           <= '0;
      x2_r           <= '0;
      x3_r           <= '0;
      m_out0_r       <= '0;
      m_out1_r       <= '0;
`ifdef DNN_DRV_TIMEOUT_EN
      wait_cnt_r     <= '0;
`endif
    end else begin
      dnn_in_ready_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      case (state_r)
        FILL: begin
          if (s_valid) begin
            case (idx_r)
              2'd0:    x0_r <= s_data;
              2'd1:    x1_r <= s_data;
              2'd2:    x2_r <= s_data;
              2'd3:    x3_r <= s_data;
              default: x0_r <= s_data;
            endcase
            idx_r <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              state_r        <= ISSUE;
              dnn_in_ready_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          got0_r  <= 1'b0;
          got1_r  <= 1'b0;
          state_r <= WAIT;
`ifdef DNN_DRV_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
        end
        WAIT: begin
          if (cap0_s) begin
            m_out0_r <= dnn_out0;
            got0_r   <= 1'b1;
          end
          if (cap1_s) begin
            m_out1_r <= dnn_out1;
            got1_r   <= 1'b1;
          end
          if (pair_done_s) begin
            state_r   <= EMIT;
            m_valid_r <= 1'b1;
          end
`ifdef DNN_DRV_TIMEOUT_EN
          // Completion on the expiry cycle takes priority over abandoning the vector
          else if (wait_cnt_r == CNT_LAST) begin
            state_r       <= FILL;
            timeout_err_r <= 1'b1;
            got0_r        <= 1'b0;
            got1_r        <= 1'b0;
            m_out0_r      <= '0;
            m_out1_r      <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
`endif
        end
        EMIT: begin
          if (m_ready) begin
            state_r   <= FILL;
            m_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= FILL;
          idx_r     <= 2'd0;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = (state_r == FILL);
  assign busy         = (state_r != FILL);
  assign dnn_in_ready = dnn_in_ready_r;
  assign dnn_x0       = x0_r;
  assign dnn_x1       = x1_r;
  assign dnn_x2       = x2_r;
  assign dnn_x3       = x3_r;
  assign m_valid      = m_valid_r;
  assign m_out0       = m_out0_r;
  assign m_out1       = m_out1_r;
`ifdef DNN_DRV_TIMEOUT_EN
  assign timeout_err  = timeout_err_r;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule
